sound_code_arbiter: RTL

Shares one PS/2 key-code source between two music-box players. Key codes strobed in by the PS/2 decoder are queued in a small FIFO. Each player pulls codes through its own four-phase data_rq/data_rd handshake, and a round-robin arbiter picks which player is served when both are waiting. The block sits between the PS/2 decoder and the music-box players, in place of a single point-to-point handshake.

---
 rtl/sound_code_arbiter_pkg.sv | 14 +
 rtl/sound_code_fifo.sv | 49 ++++
 rtl/sound_code_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/sound_code_arbiter_pkg.sv
// Shared types and constants for the sound-code arbiter: code width default,
// player count and the arbiter FSM state encoding.
package sound_code_arbiter_pkg;

  localparam int CODE_W_DEF  = 4;
  localparam int NUM_PLAYERS = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/sound_code_fifo.sv
// Synchronous FIFO holding queued key codes. Pointers carry one extra wrap bit,
// so full/empty/count fall out of a pointer compare. Push and pop together are legal.
module sound_code_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // A pop in the same cycle frees the head slot, so a full FIFO may still accept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sound_code_arbiter.sv
// Queues PS/2 key codes and hands them to two players over four-phase
// data_rq/data_rd handshakes, round-robin on ties.
module sound_code_arbiter
  import sound_code_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CODE_W     = CODE_W_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CODE_W-1:0]           ps2_data,
  input  logic                        ps2_en,
  input  logic [NUM_PLAYERS-1:0]      data_rq,
  output logic [NUM_PLAYERS-1:0]      data_rd,
  output logic [CODE_W-1:0]           sound_code,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output state_t                      state,
  output logic                        last_grant
);

  // Handshake: a player raises data_rq[i] and holds it; data_rd[i] rises when
  // sound_code is valid for it and stays high until data_rq[i] falls. data_rd then
  // drops on the next edge and stays low for at least one RELEASE cycle.

  state_t          state_next;
  logic            do_grant;
  logic            winner;
  logic            cur;
  logic [CODE_W-1:0] fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;

  sound_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CODE_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (ps2_en),
    .pop   (do_grant),
    .din   (ps2_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    winner     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty && (data_rq != '0)) begin
          do_grant   = 1'b1;
          state_next = ST_SERVE;
          // On a tie the player not served last time wins.
          if (data_rq == 2'b11) winner = ~last_grant;
          else                  winner = data_rq[1];
        end
      end
      ST_SERVE: begin
        if (!data_rq[cur]) state_next = ST_RELEASE;
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      data_rd    <= '0;
      sound_code <= '0;
      last_grant <= 1'b1;
      cur        <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state <= state_next;
      if (do_grant) begin
        data_rd    <= winner ? 2'b10 : 2'b01;
        sound_code <= fifo_dout;
        last_grant <= winner;
        cur        <= winner;
      end else if (state == ST_SERVE && state_next == ST_RELEASE) begin
        data_rd <= '0;
      end
      if (ps2_en && fifo_full && !do_grant) overflow <= 1'b1;
    end
  end

endmodule
